// File: rtl/a2d_conv_sched.sv
// Round-robin ADC128S conversion scheduler: issues the two-transaction SPI
// sequence per channel, latches results and supervises SPI completion.
module a2d_conv_sched #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYC     = 2,
    parameter int CH_LFT      = 0,
    parameter int CH_RGHT     = 4,
    parameter int CH_STEER    = 5,
    parameter int CH_BATT     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_vld,
    output logic [1:0]  cnv_ch,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WAIT1 = 3'd2,
        GAP   = 3'd3,
        RD    = 3'd4,
        WAIT2 = 3'd5,
        UPD   = 3'd6
    } state_t;

    localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             pend_r;
    logic             pend_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       rr_r;
    logic [11:0]      cap_r;
    logic             cap_ld_s;
    logic             timeout_s;
    logic             wd_exp_s;

    function automatic logic [2:0] ch_sel(input logic [1:0] idx);
        case (idx)
            2'd0:    ch_sel = 3'(CH_LFT);
            2'd1:    ch_sel = 3'(CH_RGHT);
            2'd2:    ch_sel = 3'(CH_STEER);
            2'd3:    ch_sel = 3'(CH_BATT);
            default: ch_sel = 3'(CH_LFT);
        endcase
    endfunction

    // One counter serves both the gap timer and the watchdog; it restarts on every state change.
    assign wd_exp_s = (cnt_r == TO_LAST);

    // Next-state, pending-request and watchdog decisions
    always_comb begin
        state_nxt_s = state_r;
        pend_nxt_s  = pend_r | nxt;
        timeout_s   = 1'b0;
        cap_ld_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (nxt || pend_r) begin
                    state_nxt_s = CMD;
                    pend_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                    pend_nxt_s  = 1'b0;
                end
            end
            CMD: state_nxt_s = WAIT1;
            WAIT1: begin
                if (spi_done) begin
                    state_nxt_s = (GAP_CYC > 0) ? GAP : RD;
                end else if (wd_exp_s) begin
                    state_nxt_s = IDLE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT1;
                end
            end
            GAP: begin
                if (cnt_r >= GAP_LAST) begin
                    state_nxt_s = RD;
                end else begin
                    state_nxt_s = GAP;
                end
            end
            RD: state_nxt_s = WAIT2;
            WAIT2: begin
                if (spi_done) begin
                    state_nxt_s = UPD;
                    cap_ld_s    = 1'b1;
                end else if (wd_exp_s) begin
                    state_nxt_s = IDLE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT2;
                end
            end
            UPD: state_nxt_s = IDLE;
            default: begin
                state_nxt_s = IDLE;
                pend_nxt_s  = 1'b0;
            end
        endcase
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // FSM state, pending request and shared counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            pend_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            pend_r  <= pend_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // SPI handshake outputs and busy, registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_wrt <= 1'b0;
            spi_cmd <= 16'h0000;
            busy    <= 1'b0;
        end else begin
            spi_wrt <= (state_nxt_s == CMD) || (state_nxt_s == RD);
            if (state_nxt_s == CMD) begin
                spi_cmd <= {2'b00, ch_sel(rr_r), 11'h000};
            end
            busy <= (state_nxt_s != IDLE);
        end
    end

    // Capture of the second-transaction result
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_r <= 12'h000;
        end else if (cap_ld_s) begin
            cap_r <= spi_rd_data[11:0];
        end
    end

    // Holding registers, round-robin index and update strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_r      <= 2'd0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
            cnv_vld   <= 1'b0;
            cnv_ch    <= 2'd0;
        end else begin
            cnv_vld <= (state_r == UPD);
            if (state_r == UPD) begin
                cnv_ch <= rr_r;
                rr_r   <= rr_r + 2'd1;
                case (rr_r)
                    2'd0:    lft_ld    <= cap_r;
                    2'd1:    rght_ld   <= cap_r;
                    2'd2:    steer_pot <= cap_r;
                    2'd3:    batt      <= cap_r;
                    default: lft_ld    <= lft_ld;
                endcase
            end
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as err_clr keeps it set
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (timeout_s) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_a2d_conv_sched.sv
// Self-checking bench for a2d_conv_sched: SPI/ADC stub, command and
// conversion scoreboards, vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_a2d_conv_sched;

    localparam int T = 4096;
    localparam int G = 2;
    localparam logic [15:0] EXP_CMD [4] = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
    localparam int CH_OF [4] = '{0, 4, 5, 6};

    logic        clk = 1'b0;
    logic        rst, nxt, spi_done, err_clr;
    logic [15:0] spi_rd_data;
    logic        spi_wrt, cnv_vld, busy, err;
    logic [15:0] spi_cmd;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic [1:0]  cnv_ch;

    always #5 clk = ~clk;

    a2d_conv_sched #(.TIMEOUT_CYC(T), .GAP_CYC(G)) dut (
        .clk(clk), .rst(rst), .nxt(nxt), .spi_done(spi_done), .spi_rd_data(spi_rd_data),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .steer_pot(steer_pot), .batt(batt), .cnv_vld(cnv_vld), .cnv_ch(cnv_ch),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    typedef struct { logic [1:0] ch; logic [11:0] val; } conv_t;
    typedef struct { logic [11:0] adc; logic [15:0] cmd; logic [1:0] ch; } vec_t;

    conv_t       conv_q[$];
    logic [15:0] cmd_q[$];
    logic [11:0] adc_val [8];
    logic [11:0] exp_reg [4];
    logic [15:0] cmd_hold;
    vec_t        vecs [4];
    int pass_cnt = 0, chk_cnt = 0, vld_cnt = 0, txn_cnt = 0;
    int drop_txn = -1, done_lat = 2, rr_m = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    task automatic fail(input string msg);
        chk_cnt++;
        $display("FAIL %s", msg);
    endtask

    task automatic pulse_nxt();
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
    endtask

    task automatic expect_conv(input logic [11:0] v);
        cmd_q.push_back(EXP_CMD[rr_m]);
        cmd_q.push_back(EXP_CMD[rr_m]);
        conv_q.push_back('{2'(rr_m), v});
        rr_m = (rr_m + 1) % 4;
    endtask

    task automatic wait_vld(input int target, input string nm);
        int n = 0;
        while (vld_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail($sformatf("%s: cnv_vld count %0d, want %0d", nm, vld_cnt, target));
    endtask

    // sel 0 waits for spi_wrt, sel 1 for spi_done
    task automatic wait_sig(input int sel, input string nm);
        int n = 0;
        while (!((sel == 0) ? spi_wrt : spi_done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail($sformatf("%s: signal stayed 0, want 1", nm));
    endtask

    // SPI master + ADC stub; response drives change mid high phase
    initial begin
        spi_done    = 1'b0;
        spi_rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (spi_wrt === 1'b1) begin
                txn_cnt++;
                if (txn_cnt != drop_txn) begin
                    repeat (done_lat) @(posedge clk);
                    #1;
                    spi_rd_data = {4'hA, adc_val[spi_cmd[13:11]]};
                    spi_done    = 1'b1;
                    @(posedge clk);
                    #1;
                    spi_done    = 1'b0;
                    spi_rd_data = 16'h0000;
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        logic [15:0] ec;
        conv_t       ce;
        forever begin
            @(negedge clk);
            if (rst) begin
                foreach (exp_reg[i]) exp_reg[i] = 12'h000;
            end else begin
                if (spi_wrt) begin
                    if (cmd_q.size() == 0) fail("unexpected_wrt: got spi_wrt=1, want 0");
                    else begin
                        ec = cmd_q.pop_front();
                        chk("spi_cmd", 32'(spi_cmd), 32'(ec));
                    end
                    cmd_hold = spi_cmd;
                end
                if (spi_done && busy) chk("cmd_stable", 32'(spi_cmd), 32'(cmd_hold));
                if (cnv_vld) begin
                    vld_cnt++;
                    if (conv_q.size() == 0) fail("unexpected_cnv_vld: got 1, want 0");
                    else begin
                        ce = conv_q.pop_front();
                        exp_reg[ce.ch] = ce.val;
                        chk("cnv_ch", 32'(cnv_ch), 32'(ce.ch));
                        chk("lft_ld", 32'(lft_ld), 32'(exp_reg[0]));
                        chk("rght_ld", 32'(rght_ld), 32'(exp_reg[1]));
                        chk("steer_pot", 32'(steer_pot), 32'(exp_reg[2]));
                        chk("batt", 32'(batt), 32'(exp_reg[3]));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: run exceeded time limit");
        $fatal(1, "bench aborted");
    end

    initial begin
        int base, k, bad;
        vecs[0] = '{12'h300, 16'h0000, 2'd0};
        vecs[1] = '{12'h300, 16'h2000, 2'd1};
        vecs[2] = '{12'h800, 16'h2800, 2'd2};
        vecs[3] = '{12'hC00, 16'h3000, 2'd3};
        foreach (adc_val[i]) adc_val[i] = 12'h000;
        rst = 1'b1; nxt = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_spi_wrt", 32'(spi_wrt), 32'd0);
        chk("rst_spi_cmd", 32'(spi_cmd), 32'd0);
        chk("rst_regs", 32'({lft_ld, rght_ld}), 32'd0);
        chk("rst_regs2", 32'({steer_pot, batt}), 32'd0);
        chk("rst_flags", 32'({cnv_vld, cnv_ch, busy, err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // first round from the vector table
        for (int i = 0; i < 4; i++) begin
            adc_val[CH_OF[i]] = vecs[i].adc;
            cmd_q.push_back(vecs[i].cmd);
            cmd_q.push_back(vecs[i].cmd);
            conv_q.push_back('{vecs[i].ch, vecs[i].adc});
            base = vld_cnt;
            pulse_nxt();
            wait_vld(base + 1, "round_vld");
        end
        rr_m = 0;

        // fifth conversion wraps to the left load cell
        adc_val[0] = 12'h020;
        expect_conv(12'h020);
        base = vld_cnt;
        pulse_nxt();
        wait_vld(base + 1, "wrap_vld");

        // nxt three times while busy: exactly one extra conversion
        adc_val[4] = 12'h111;
        adc_val[5] = 12'h222;
        expect_conv(12'h111);
        expect_conv(12'h222);
        base = vld_cnt;
        pulse_nxt();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pulse_nxt();
        end
        wait_vld(base + 2, "pending_vld");
        repeat (40) @(negedge clk);
        chk("pending_count", 32'(vld_cnt - base), 32'd2);
        chk("pending_idle", 32'(busy), 32'd0);

        // watchdog: battery conversion with spi_done withheld in WAIT2
        drop_txn = txn_cnt + 2;
        cmd_q.push_back(EXP_CMD[3]);
        cmd_q.push_back(EXP_CMD[3]);
        base = vld_cnt;
        pulse_nxt();
        wait_sig(0, "to_wrt1");
        @(negedge clk);
        wait_sig(0, "to_wrt2");
        @(negedge clk);
        k = 0;
        while (!err && k < 2 * T + 20) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_latency", 32'(k), 32'(T));
        chk("timeout_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("timeout_no_vld", 32'(vld_cnt - base), 32'd0);
        adc_val[6] = 12'h5A5;
        expect_conv(12'h5A5);
        pulse_nxt();
        wait_vld(base + 1, "retry_vld");
        chk("err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", 32'(err), 32'd0);

        // reset during WAIT1 with a late spi_done
        done_lat = 4;
        cmd_q.push_back(EXP_CMD[0]);
        pulse_nxt();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_regs", 32'({lft_ld, rght_ld}), 32'd0);
        chk("mid_rst_regs2", 32'({steer_pot, batt}), 32'd0);
        chk("mid_rst_flags", 32'({spi_wrt, cnv_vld, cnv_ch, busy, err}), 32'd0);
        chk("mid_rst_cmd", 32'(spi_cmd), 32'd0);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (spi_wrt || busy || cnv_vld) bad++;
        end
        chk("mid_rst_quiet", 32'(bad), 32'd0);
        done_lat = 2;
        rr_m = 0;

        // gap spacing, then nxt during UPD restarts on the following clock
        expect_conv(adc_val[0]);
        expect_conv(adc_val[4]);
        base = vld_cnt;
        pulse_nxt();
        wait_sig(0, "gap_wrt1");
        wait_sig(1, "gap_done1");
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!spi_wrt && k < 20);
        chk("gap_spacing", 32'(k), 32'(G + 1));
        wait_sig(1, "gap_done2");
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        chk("upd_vld", 32'(cnv_vld), 32'd1);
        @(negedge clk);
        chk("upd_restart", 32'(spi_wrt), 32'd1);
        wait_vld(base + 2, "upd_pending_vld");
        repeat (20) @(negedge clk);
        chk("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
        chk("conv_q_empty", 32'(conv_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
